// File: rtl/sched_pkg.sv
// Shared types and default sizing for the round-robin process scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sched_pkg;

  localparam int NPROC_DEF = 4;
  localparam int AW_DEF    = 32;

  // Scheduler control FSM
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SAVE,
    PICK,
    ISSUE
  } fsm_t;

  // Per-slot lifecycle
  typedef enum logic [1:0] {
    EMPTY,
    READY,
    RUNNING,
    DONE
  } slot_st_t;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Round-robin pick of the next READY slot, starting after cur_i, cur_i itself last.
// Latency: combinational; the result is registered by the scheduler's PICK state.
// Backpressure: none.
// Ports: ready_i (READY vector), cur_i (current slot) -> found_o, grant_o (granted index).
module sched_rr_arbiter
  import sched_pkg::*;
#(
  parameter  int NPROC = NPROC_DEF,
  localparam int SW    = $clog2(NPROC)
) (
  input  logic [NPROC-1:0] ready_i,
  input  logic [SW-1:0]    cur_i,
  output logic             found_o,
  output logic [SW-1:0]    grant_o
);

  logic [SW-1:0] idx;

  // Walk from the farthest candidate (cur_i itself) towards the nearest
  // (cur_i+1) so the nearest READY slot is the last one to overwrite grant_o.
  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int k = NPROC; k >= 1; k--) begin
      idx = SW'((int'(cur_i) + k) % NPROC);
      if (ready_i[idx]) begin
        found_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: saves the interrupted PC and dispatches the next READY slot.
// Latency: ContextChangeBack rising edge (or load from IDLE) to next_valid pulse is 3 cycles.
// Backpressure: none; next_valid is a one-cycle pulse, loads are accepted in every state.
// Ports: CLK, reset (sync, active-high); ContextChangeBack/EndProcess/savedLine from the PC;
//        load_valid/load_slot/load_addr register a process; next_valid/next_addr/cur_slot
//        dispatch output; idle when nothing is READY or RUNNING.
// Build option SCHED_STATS_EN: per-slot 16-bit saturating dispatch counters read
//        combinationally through stat_slot/stat_count.
module process_scheduler
  import sched_pkg::*;
#(
  parameter  int NPROC = NPROC_DEF,
  parameter  int AW    = AW_DEF,
  localparam int SW    = $clog2(NPROC)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          ContextChangeBack,
  input  logic          EndProcess,
  input  logic [AW-1:0] savedLine,
  input  logic          load_valid,
  input  logic [SW-1:0] load_slot,
  input  logic [AW-1:0] load_addr,
`ifdef SCHED_STATS_EN
  input  logic [SW-1:0] stat_slot,
  output logic [15:0]   stat_count,
`endif
  output logic          next_valid,
  output logic [AW-1:0] next_addr,
  output logic [SW-1:0] cur_slot,
  output logic          idle
);

  fsm_t           state_q, state_d;
  logic           ccb_q;
  logic           end_q;
  logic [AW-1:0]  saved_q;
  logic [SW-1:0]  cur_q;
  slot_st_t       st_q [NPROC];
  logic [AW-1:0]  pc_q [NPROC];
  logic           next_valid_q;
  logic [AW-1:0]  next_addr_q;

  logic             ccb_rise;
  logic [NPROC-1:0] ready_vec;
  logic [NPROC-1:0] load_hit;
  logic             arb_found;
  logic [SW-1:0]    arb_grant;

  assign ccb_rise = ContextChangeBack & ~ccb_q;

  // A load only lands on a free slot; a RUNNING slot (including one being
  // saved this cycle) or a READY slot keeps its contents.
  always_comb begin
    ready_vec = '0;
    load_hit  = '0;
    for (int i = 0; i < NPROC; i++) begin
      ready_vec[i] = (st_q[i] == READY);
      load_hit[i]  = load_valid && (load_slot == SW'(i)) &&
                     ((st_q[i] == EMPTY) || (st_q[i] == DONE));
    end
  end

  sched_rr_arbiter #(.NPROC(NPROC)) u_arb (
    .ready_i (ready_vec),
    .cur_i   (cur_q),
    .found_o (arb_found),
    .grant_o (arb_grant)
  );

  always_ff @(posedge CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|ready_vec) state_d = PICK;
      RUN:     if (ccb_rise)   state_d = SAVE;
      SAVE:    state_d = PICK;
      PICK:    state_d = arb_found ? ISSUE : IDLE;
      ISSUE:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ccb_q        <= 1'b0;
      end_q        <= 1'b0;
      saved_q      <= '0;
      cur_q        <= '0;
      next_valid_q <= 1'b0;
      next_addr_q  <= '0;
      for (int i = 0; i < NPROC; i++) begin
        st_q[i] <= EMPTY;
        pc_q[i] <= '0;
      end
    end else begin
      ccb_q        <= ContextChangeBack;
      next_valid_q <= 1'b0;
      // EndProcess and savedLine belong to the edge that ended the quantum.
      if ((state_q == RUN) && ccb_rise) begin
        end_q   <= EndProcess;
        saved_q <= savedLine;
      end
      for (int i = 0; i < NPROC; i++) begin
        if ((state_q == SAVE) && (cur_q == SW'(i))) begin
          if (end_q) begin
            st_q[i] <= DONE;
          end else begin
            st_q[i] <= READY;
            pc_q[i] <= saved_q;
          end
        end else if ((state_q == PICK) && arb_found && (arb_grant == SW'(i))) begin
          st_q[i] <= RUNNING;
        end else if (load_hit[i]) begin
          st_q[i] <= READY;
          pc_q[i] <= load_addr;
        end
      end
      if ((state_q == PICK) && arb_found) cur_q <= arb_grant;
      if (state_q == ISSUE) begin
        next_valid_q <= 1'b1;
        next_addr_q  <= pc_q[cur_q];
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] cnt_q [NPROC];

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        if (load_hit[i]) begin
          cnt_q[i] <= '0;
        end else if ((state_q == ISSUE) && (cur_q == SW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_count = cnt_q[stat_slot];
`endif

  assign next_valid = next_valid_q;
  assign next_addr  = next_addr_q;
  assign cur_slot   = cur_q;
  assign idle       = (state_q == IDLE);

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler (NPROC=4, AW=32) with a dispatch scoreboard.
// Latency: expects next_valid exactly 3 cycles after a load from IDLE or a ContextChangeBack edge.
// Backpressure: n/a.
module tb_process_scheduler;
  import sched_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          reset;
  logic          ContextChangeBack;
  logic          EndProcess;
  logic [AW-1:0] savedLine;
  logic          load_valid;
  logic [1:0]    load_slot;
  logic [AW-1:0] load_addr;
  logic          next_valid;
  logic [AW-1:0] next_addr;
  logic [1:0]    cur_slot;
  logic          idle;
`ifdef SCHED_STATS_EN
  logic [1:0]    stat_slot;
  logic [15:0]   stat_count;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    slot;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  process_scheduler #(.NPROC(NP), .AW(AW)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .ContextChangeBack (ContextChangeBack),
    .EndProcess        (EndProcess),
    .savedLine         (savedLine),
    .load_valid        (load_valid),
    .load_slot         (load_slot),
    .load_addr         (load_addr),
`ifdef SCHED_STATS_EN
    .stat_slot         (stat_slot),
    .stat_count        (stat_count),
`endif
    .next_valid        (next_valid),
    .next_addr         (next_addr),
    .cur_slot          (cur_slot),
    .idle              (idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_disp(input logic [AW-1:0] addr, input logic [1:0] slot);
    exp_t e;
    e.addr = addr;
    e.slot = slot;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [1:0] slot, input logic [AW-1:0] addr);
    load_valid = 1'b1;
    load_slot  = slot;
    load_addr  = addr;
    tick(1);
    load_valid = 1'b0;
  endtask

  // Called one negedge after the triggering posedge; pulse expected after edge +3.
  task automatic wait_issue(input string tag);
    exp_t e;
    tick(1);
    load_valid = 1'b0;
    chk({tag, "_early1"}, next_valid, 1'b0);
    tick(1);
    chk({tag, "_early2"}, next_valid, 1'b0);
    tick(1);
    chk({tag, "_vld"}, next_valid, 1'b1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: observed=dispatch expected=no-entry-queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, next_addr, e.addr);
      chk({tag, "_slot"}, cur_slot, e.slot);
    end
    tick(1);
    chk({tag, "_pulse"}, next_valid, 1'b0);
  endtask

  task automatic no_dispatch(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      load_valid = 1'b0;
      chk(tag, next_valid, 1'b0);
    end
  endtask

  // Produces one ContextChangeBack rising edge; leaves the level high.
  // Optionally drives a load during the SAVE cycle (between edge k and k+1).
  task automatic ccb_edge(input logic e, input logic [AW-1:0] s,
                          input logic ld_en, input logic [1:0] ld_slot,
                          input logic [AW-1:0] ld_addr);
    ContextChangeBack = 1'b0;
    tick(1);
    ContextChangeBack = 1'b1;
    EndProcess        = e;
    savedLine         = s;
    tick(1);
    if (ld_en) begin
      load_valid = 1'b1;
      load_slot  = ld_slot;
      load_addr  = ld_addr;
    end
  endtask

  initial begin
    reset             = 1'b1;
    ContextChangeBack = 1'b0;
    EndProcess        = 1'b0;
    savedLine         = '0;
    load_valid        = 1'b0;
    load_slot         = '0;
    load_addr         = '0;
`ifdef SCHED_STATS_EN
    stat_slot         = '0;
`endif
    tick(2);
    chk("rst_vld",  next_valid, 1'b0);
    chk("rst_addr", next_addr,  32'h0);
    chk("rst_slot", cur_slot,   2'd0);
    chk("rst_idle", idle,       1'b1);
    reset = 1'b0;
    no_dispatch("empty_quiet", 3);
    chk("empty_idle", idle, 1'b1);

    // First dispatch straight from IDLE
    expect_disp(32'h100, 2'd0);
    do_load(2'd0, 32'h100);
    wait_issue("ld0");
    chk("run_idle", idle, 1'b0);

    // Load while running: no dispatch until the quantum ends
    do_load(2'd1, 32'h200);
    no_dispatch("ld1_quiet", 3);

    // Quantum expiry on slot 0; level held high and falling edge are ignored
    expect_disp(32'h200, 2'd1);
    ccb_edge(1'b0, 32'h12C, 1'b0, 2'd0, 32'h0);
    wait_issue("sw1");
    no_dispatch("level_hi", 3);
    ContextChangeBack = 1'b0;
    no_dispatch("fall", 2);

    // Slot 1 ends; slot 0 resumes at its saved PC
    expect_disp(32'h12C, 2'd0);
    ccb_edge(1'b1, 32'h999, 1'b0, 2'd0, 32'h0);
    wait_issue("end1");

    // Slot 0 ends too: nothing left
    ccb_edge(1'b1, 32'h0, 1'b0, 2'd0, 32'h0);
    no_dispatch("all_done", 6);
    chk("all_done_idle", idle, 1'b1);
    chk("all_done_slot", cur_slot, 2'd0);

    // Only slot 3 ready: dispatched, then re-dispatched to itself
    expect_disp(32'h300, 2'd3);
    do_load(2'd3, 32'h300);
    wait_issue("ld3");
    expect_disp(32'h340, 2'd3);
    ccb_edge(1'b0, 32'h340, 1'b0, 2'd0, 32'h0);
    wait_issue("redisp3");

    // Reload DONE slot 0; search from slot 3 wraps to slot 0
    do_load(2'd0, 32'h400);
    expect_disp(32'h400, 2'd0);
    ccb_edge(1'b0, 32'h350, 1'b0, 2'd0, 32'h0);
    wait_issue("wrap0");

    // Loads to a RUNNING and to a READY slot are ignored
    do_load(2'd0, 32'h777);
    do_load(2'd3, 32'h778);
    expect_disp(32'h350, 2'd3);
    ccb_edge(1'b0, 32'h410, 1'b0, 2'd0, 32'h0);
    wait_issue("ign_rdy");
    expect_disp(32'h410, 2'd0);
    ccb_edge(1'b0, 32'h360, 1'b0, 2'd0, 32'h0);
    wait_issue("ign_run");

`ifdef SCHED_STATS_EN
    stat_slot = 2'd0;
    tick(1);
    chk("stat0", stat_count, 16'd2);
    stat_slot = 2'd3;
    tick(1);
    chk("stat3", stat_count, 16'd3);
`endif

    // SAVE and load on the same slot in the same cycle: saved PC kept
    expect_disp(32'h360, 2'd3);
    ccb_edge(1'b0, 32'h420, 1'b1, 2'd0, 32'h888);
    wait_issue("save_vs_load");
    expect_disp(32'h420, 2'd0);
    ccb_edge(1'b0, 32'h370, 1'b0, 2'd0, 32'h0);
    wait_issue("save_kept");

    // Reset while PICK is in flight
    ccb_edge(1'b0, 32'h430, 1'b0, 2'd0, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_vld",  next_valid, 1'b0);
    chk("mid_rst_addr", next_addr,  32'h0);
    chk("mid_rst_slot", cur_slot,   2'd0);
    chk("mid_rst_idle", idle,       1'b1);
    reset             = 1'b0;
    ContextChangeBack = 1'b0;
    no_dispatch("mid_rst_quiet", 6);
    chk("mid_rst_empty", idle, 1'b1);
`ifdef SCHED_STATS_EN
    stat_slot = 2'd0;
    tick(1);
    chk("stat0_rst", stat_count, 16'd0);
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_drain: observed=%0d pending expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/process_scheduler.md
# process_scheduler

Round-robin process scheduler feeding the PC's context-switch path. It holds a saved-PC table for up to NPROC user processes and captures the interrupted PC (`savedLine`) when the PC hands control back to the OS (`ContextChangeBack`), or retires the process on `EndProcess`. It then selects the next ready process and presents its resume address for one cycle to the OS/ROM path that drives the PC's `Read_Data_Out`.

## Interface
- NPROC, 4: number of process slots, 2..16.
- AW, 32: address width.
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ContextChangeBack  in  1  level from PC; a rising edge marks a quantum expiry or end of process.
- EndProcess  in  1  sampled together with the ContextChangeBack rising edge; 1 means the current process has terminated.
- savedLine  in  AW  interrupted PC of the current process.
- load_valid  in  1  one-cycle strobe that registers a new process.
- load_slot  in  $clog2(NPROC)  target slot.
- load_addr  in  AW  process start address.
- next_valid  out  1  one-cycle pulse: next_addr and cur_slot are valid.
- next_addr  out  AW  resume address of the dispatched process.
- cur_slot  out  $clog2(NPROC)  slot currently running.
- idle  out  1  no READY or RUNNING slot exists.

## Operation
- Slot state is one of EMPTY, READY, RUNNING, DONE. Each slot also holds an AW-bit PC.
- FSM states: IDLE, RUN, SAVE, PICK, ISSUE.
- IDLE:
  - Waits for any slot to become READY, then goes to PICK.
  - `idle` is 1 only in IDLE.
- RUN:
  - A ContextChangeBack rising edge, detected against a registered copy, moves the FSM to SAVE.
  - Levels and falling edges are ignored.
- SAVE:
  - EndProcess=1: the cur_slot state becomes DONE and the PC is not written.
  - Otherwise: the cur_slot PC is set to savedLine and its state to READY.
- PICK:
  - Finds the first READY slot searching cur_slot+1, cur_slot+2, … modulo NPROC, with cur_slot itself searched last.
  - Found: that slot becomes RUNNING, cur_slot is updated, and the FSM goes to ISSUE.
  - None found: go to IDLE.
- ISSUE: next_addr is set to the slot PC, next_valid is 1, and the FSM goes to RUN.
- Loads:
  - load_valid to an EMPTY or DONE slot sets PC=load_addr and state=READY.
  - A load to a READY or RUNNING slot is ignored.
  - A load is accepted in any FSM state.
- Simultaneous events:
  - A SAVE and a load to the same slot in the same cycle: SAVE wins and the load is dropped.
  - A load and PICK in the same cycle: the new slot is not visible to that PICK.
- A ContextChangeBack edge arriving outside RUN is ignored; the PC does not raise it before dispatch.

## Timing
- Reset values:
  - next_valid=0, next_addr=0, cur_slot=0, idle=1.
  - FSM=IDLE; all slots EMPTY with PC=0; edge register=0.
- Reset mid-operation aborts any SAVE, PICK or ISSUE with no partial slot write.
- Let edge k be the posedge where ContextChangeBack=1 and its registered copy=0. Then:
  - k+1: slot written (SAVE).
  - k+2: selection done (PICK).
  - k+3: next_valid=1 and next_addr valid (ISSUE).
- Total latency is 3 cycles. next_valid is high for exactly one cycle.
- From IDLE, a load at edge j gives next_valid at edge j+3: IDLE→PICK at j+1, PICK→ISSUE at j+2, output at j+3.
- Wrap-around: with cur_slot=NPROC-1, the search starts at slot 0.
- If the only READY slot is cur_slot, that same slot is re-dispatched with its saved PC.

## Configuration
- SCHED_STATS_EN defined:
  - Adds a 16-bit saturating dispatch counter per slot, incremented in ISSUE and cleared by reset or by a load to that slot.
  - Adds the ports stat_slot (in, $clog2(NPROC)) and stat_count (out, 16), a combinational read.
- SCHED_STATS_EN undefined: no counters and no stat ports; behaviour is otherwise identical.

## Structure
- Package sched_pkg holds:
  - the fsm_t enum (IDLE/RUN/SAVE/PICK/ISSUE);
  - the slot_st_t enum (EMPTY/READY/RUNNING/DONE);
  - the default NPROC and AW constants.
- Sub-module sched_rr_arbiter:
  - inputs: READY vector and cur_slot;
  - outputs: found flag and granted index;
  - purely combinational, registered by PICK.

## Test plan
- Load slots 0 and 1 at 0x100 and 0x200 from reset → next_valid at +3 cycles with next_addr=0x100 and cur_slot=0.
- Raise ContextChangeBack with savedLine=0x12C and EndProcess=0 → 3 cycles later next_addr=0x200 and cur_slot=1; the slot 0 PC reads back as 0x12C on the next rotation.
- Slot 1 running, EndProcess=1 on the edge → slot 1 DONE, slot 0 dispatched at 0x12C; a later edge with EndProcess=1 → idle=1 and no next_valid.
- NPROC=4, only slot 3 READY, cur_slot=3, edge → slot 3 re-dispatched; then load slot 0 → next rotation picks slot 0 (wrap).
- Load to the RUNNING slot → ignored with PC unchanged. Same-cycle SAVE and load on one slot → the savedLine value is kept.
- Assert reset during PICK → all outputs at reset values and every slot EMPTY. With SCHED_STATS_EN, stat_count for slot 0 is 2 after two dispatches, and 0 after reset.
